// File: rtl/memory_arbiter.sv
// memory_arbiter: serialises fetch and data accesses onto one single-port synchronous RAM.
// Define MEMORY_ARBITER_ROUND_ROBIN_EN for round-robin tie-break; default is data-over-fetch priority.
module memory_arbiter #(
    parameter int unsigned MEM_WORDS = 8192
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fetch_req,
    input  logic [31:0] fetch_a,
    output logic        fetch_gnt,
    output logic        fetch_valid,
    output logic [31:0] fetch_dout,
    input  logic        data_req,
    input  logic        data_rw,
    input  logic [31:0] data_a,
    input  logic [31:0] data_din,
    output logic        data_gnt,
    output logic        data_valid,
    output logic [31:0] data_dout,
    output logic [31:0] ram_a,
    output logic [31:0] ram_din,
    output logic        ram_rw,
    input  logic [31:0] ram_dout
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    state_t state, state_nxt;
    logic   arb;
    logic   respond;
    logic   data_wins;
    logic   fetch_in_range;
    logic   data_in_range;
    logic   sel_data;
    logic   sel_read;
    logic   sel_oor;

    assign fetch_in_range = (fetch_a < MEM_WORDS);
    assign data_in_range  = (data_a < MEM_WORDS);
    assign respond        = (state == WAIT);

`ifdef MEMORY_ARBITER_ROUND_ROBIN_EN
    // last_data = 1 means the previous grant went to data; reset value favours fetch on the first tie
    logic last_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_data <= 1'b1;
        end else if (arb) begin
            last_data <= data_wins;
        end
    end

    assign data_wins = data_req && (!fetch_req || !last_data);
`else
    assign data_wins = data_req;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        arb       = 1'b0;
        unique case (state)
            IDLE: begin
                if (fetch_req || data_req) begin
                    arb       = 1'b1;
                    state_nxt = ISSUE;
                end
            end
            ISSUE: state_nxt = WAIT;
            WAIT: begin
                if (fetch_req || data_req) begin
                    arb       = 1'b1;
                    state_nxt = ISSUE;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Response for the finishing access and the next grant can share the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_gnt   <= 1'b0;
            fetch_valid <= 1'b0;
            fetch_dout  <= '0;
            data_gnt    <= 1'b0;
            data_valid  <= 1'b0;
            data_dout   <= '0;
            ram_a       <= '0;
            ram_din     <= '0;
            ram_rw      <= 1'b0;
            sel_data    <= 1'b0;
            sel_read    <= 1'b0;
            sel_oor     <= 1'b0;
        end else begin
            fetch_gnt   <= 1'b0;
            data_gnt    <= 1'b0;
            fetch_valid <= 1'b0;
            data_valid  <= 1'b0;
            ram_rw      <= 1'b0;

            if (respond) begin
                if (sel_data) begin
                    data_valid <= 1'b1;
                    if (sel_read) begin
                        data_dout <= sel_oor ? 32'h0 : ram_dout;
                    end
                end else begin
                    fetch_valid <= 1'b1;
                    fetch_dout  <= sel_oor ? 32'h0 : ram_dout;
                end
            end

            if (arb) begin
                sel_data <= data_wins;
                if (data_wins) begin
                    data_gnt <= 1'b1;
                    ram_a    <= data_a;
                    ram_din  <= data_din;
                    ram_rw   <= data_rw && data_in_range;
                    sel_read <= !data_rw;
                    sel_oor  <= !data_in_range;
                end else begin
                    fetch_gnt <= 1'b1;
                    ram_a     <= fetch_a;
                    sel_read  <= 1'b1;
                    sel_oor   <= !fetch_in_range;
                end
            end
        end
    end

endmodule

// File: tb/tb_memory_arbiter.sv
// Self-checking bench for memory_arbiter: behavioural RAM, shadow-memory reference model, randomized traffic.
module tb_memory_arbiter;

    localparam int unsigned WORDS = 8192;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        fetch_req, fetch_gnt, fetch_valid;
    logic [31:0] fetch_a, fetch_dout;
    logic        data_req, data_rw, data_gnt, data_valid;
    logic [31:0] data_a, data_din, data_dout;
    logic [31:0] ram_a, ram_din, ram_dout;
    logic        ram_rw;

    logic        pl_en;
    logic [12:0] pl_a;
    logic [31:0] pl_d;
    logic [31:0] mem [0:WORDS-1];

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] shadow [0:WORDS-1];
    bit          model_last_data;
    logic [31:0] model_fetch_dout;
    logic [31:0] model_data_dout;

    always #5 clk = ~clk;

    memory_arbiter #(.MEM_WORDS(WORDS)) dut (
        .clk(clk), .rst_n(rst_n),
        .fetch_req(fetch_req), .fetch_a(fetch_a), .fetch_gnt(fetch_gnt),
        .fetch_valid(fetch_valid), .fetch_dout(fetch_dout),
        .data_req(data_req), .data_rw(data_rw), .data_a(data_a), .data_din(data_din),
        .data_gnt(data_gnt), .data_valid(data_valid), .data_dout(data_dout),
        .ram_a(ram_a), .ram_din(ram_din), .ram_rw(ram_rw), .ram_dout(ram_dout)
    );

    // Single-port synchronous RAM with a registered read port; pl_* is a bench-only preload path.
    always @(posedge clk) begin
        if (pl_en) mem[pl_a] <= pl_d;
        else if (ram_rw && ram_a < WORDS) mem[ram_a[12:0]] <= ram_din;
        ram_dout <= (ram_a < WORDS) ? mem[ram_a[12:0]] : 32'hBAD0_BAD0;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        model_last_data  = 1'b1;
        model_fetch_dout = 32'h0;
        model_data_dout  = 32'h0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        model_reset();
        n_tests++;
        if ({fetch_gnt, fetch_valid, fetch_dout, data_gnt, data_valid, data_dout, ram_a, ram_din, ram_rw} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: fg=%b fv=%b fd=%h dg=%b dv=%b dd=%h ra=%h rd=%h rw=%b, required all 0",
                     fetch_gnt, fetch_valid, fetch_dout, data_gnt, data_valid, data_dout, ram_a, ram_din, ram_rw);
        end
        rst_n = 1'b1;
        tick();
        tick();
        n_tests++;
        if ({fetch_gnt, data_gnt, ram_rw} !== 3'b000) begin
            n_fail++;
            $display("FAIL idle_no_grant: fg=%b dg=%b rw=%b, required 0", fetch_gnt, data_gnt, ram_rw);
        end
    endtask

    task automatic preload();
        for (int i = 0; i < 65; i++) begin
            pl_en = 1'b1;
            pl_a  = (i == 64) ? 13'd8191 : 13'(i);
            pl_d  = (i == 5) ? 32'hE3A0_0001 : $urandom;
            shadow[pl_a] = pl_d;
            tick();
        end
        pl_en = 1'b0;
    endtask

    // One isolated access: grant one cycle after request, valid two cycles after grant.
    task automatic do_access(input bit is_data, input bit rw, input logic [31:0] a, input logic [31:0] d);
        bit          in_rng, got;
        logic [31:0] exp_dout;
        in_rng = (a < WORDS);
        if (is_data) begin
            data_req = 1'b1; data_rw = rw; data_a = a; data_din = d;
        end else begin
            fetch_req = 1'b1; fetch_a = a;
        end
        tick();
        got = is_data ? data_gnt : fetch_gnt;
        n_tests++;
        if (!got || (is_data ? fetch_gnt : data_gnt) !== 1'b0) begin
            n_fail++;
            $display("FAIL gnt_latency: fetch_gnt=%b data_gnt=%b, required grant to %s only",
                     fetch_gnt, data_gnt, is_data ? "data" : "fetch");
        end
        for (int i = 0; i < 4 && !got; i++) begin
            tick();
            got = is_data ? data_gnt : fetch_gnt;
        end
        fetch_req = 1'b0;
        data_req  = 1'b0;
        if (!got) begin
            n_tests++;
            n_fail++;
            $display("FAIL gnt_timeout: no grant for %s a=%h within bound", is_data ? "data" : "fetch", a);
            return;
        end
        model_last_data = is_data;
        n_tests++;
        if (ram_a !== a || ram_rw !== (is_data && rw && in_rng) || (is_data && ram_din !== d)) begin
            n_fail++;
            $display("FAIL issue_bus: ram_a=%h ram_rw=%b ram_din=%h, required a=%h rw=%b din=%h",
                     ram_a, ram_rw, ram_din, a, is_data && rw && in_rng, d);
        end
        if (is_data && rw && in_rng) shadow[a[12:0]] = d;
        exp_dout = in_rng ? shadow[a[12:0]] : 32'h0;
        tick();
        n_tests++;
        if ({ram_rw, fetch_valid, data_valid, fetch_gnt, data_gnt} !== 5'b0) begin
            n_fail++;
            $display("FAIL wait_quiet: rw=%b fv=%b dv=%b fg=%b dg=%b, required all 0",
                     ram_rw, fetch_valid, data_valid, fetch_gnt, data_gnt);
        end
        tick();
        if (!is_data) model_fetch_dout = exp_dout;
        else if (!rw) model_data_dout = exp_dout;
        n_tests++;
        if (fetch_valid !== !is_data || data_valid !== is_data) begin
            n_fail++;
            $display("FAIL valid_pulse: fv=%b dv=%b, required fv=%b dv=%b", fetch_valid, data_valid, !is_data, is_data);
        end
        n_tests++;
        if (fetch_dout !== model_fetch_dout || data_dout !== model_data_dout) begin
            n_fail++;
            $display("FAIL dout a=%h: fetch_dout=%h data_dout=%h, required %h %h",
                     a, fetch_dout, data_dout, model_fetch_dout, model_data_dout);
        end
        tick();
        n_tests++;
        if ({fetch_valid, data_valid, fetch_gnt, data_gnt} !== 4'b0) begin
            n_fail++;
            $display("FAIL valid_one_cycle: fv=%b dv=%b fg=%b dg=%b, required 0", fetch_valid, data_valid, fetch_gnt, data_gnt);
        end
    endtask

    task automatic test_single_fetch();
        do_access(1'b0, 1'b0, 32'd5, 32'h0);
        n_tests++;
        if (fetch_dout !== 32'hE3A0_0001 || data_dout !== 32'h0) begin
            n_fail++;
            $display("FAIL single_fetch: fetch_dout=%h data_dout=%h, required e3a00001 0", fetch_dout, data_dout);
        end
    endtask

    task automatic test_write_read();
        do_access(1'b1, 1'b1, 32'd10, 32'hDEAD_BEEF);
        do_access(1'b1, 1'b0, 32'd10, 32'h0);
        n_tests++;
        if (data_dout !== 32'hDEAD_BEEF) begin
            n_fail++;
            $display("FAIL write_read: data_dout=%h, required deadbeef", data_dout);
        end
    endtask

    task automatic test_out_of_range();
        do_access(1'b1, 1'b1, 32'd8192, 32'h1);
        do_access(1'b1, 1'b0, 32'd8192, 32'h0);
        do_access(1'b1, 1'b0, 32'd8191, 32'h0);
        do_access(1'b0, 1'b0, 32'hFFFF_FFFF, 32'h0);
        do_access(1'b0, 1'b0, 32'd8191, 32'h0);
    endtask

    task automatic test_reset_mid_access();
        fetch_req = 1'b1;
        fetch_a   = 32'd5;
        tick();
        fetch_req = 1'b0;
        n_tests++;
        if (fetch_gnt !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_reset_gnt: fetch_gnt=%b, required 1", fetch_gnt);
        end
        tick();
        rst_n = 1'b0;
        #1;
        model_reset();
        n_tests++;
        if ({fetch_gnt, fetch_valid, fetch_dout, data_gnt, data_valid, data_dout, ram_a, ram_din, ram_rw} !== '0) begin
            n_fail++;
            $display("FAIL mid_reset_outputs: fv=%b fd=%h dd=%h ra=%h, required all 0", fetch_valid, fetch_dout, data_dout, ram_a);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            n_tests++;
            if (fetch_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL mid_reset_no_valid: fetch_valid=%b, required 0", fetch_valid);
            end
        end
        rst_n = 1'b1;
        tick();
        do_access(1'b0, 1'b0, 32'd5, 32'h0);
    endtask

    // Both requesters hold req high for four back-to-back accesses.
    task automatic test_tie();
        bit prev_data, exp_data;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        model_reset();
        tick();
        fetch_a = 32'd3; data_a = 32'd7; data_rw = 1'b0; data_din = 32'h0;
        fetch_req = 1'b1; data_req = 1'b1;
        prev_data = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
`ifdef MEMORY_ARBITER_ROUND_ROBIN_EN
            exp_data = !model_last_data;
`else
            exp_data = 1'b1;
`endif
            if (k > 0) begin
                if (prev_data) model_data_dout = shadow[7];
                else model_fetch_dout = shadow[3];
                n_tests++;
                if (data_valid !== prev_data || fetch_valid !== !prev_data ||
                    data_dout !== model_data_dout || fetch_dout !== model_fetch_dout) begin
                    n_fail++;
                    $display("FAIL tie_response %0d: dv=%b fv=%b dd=%h fd=%h, required dv=%b fv=%b dd=%h fd=%h",
                             k, data_valid, fetch_valid, data_dout, fetch_dout,
                             prev_data, !prev_data, model_data_dout, model_fetch_dout);
                end
            end
            if (k == 4) break;
            n_tests++;
            if (data_gnt !== exp_data || fetch_gnt !== !exp_data) begin
                n_fail++;
                $display("FAIL tie_grant %0d: data_gnt=%b fetch_gnt=%b, required %b %b",
                         k, data_gnt, fetch_gnt, exp_data, !exp_data);
            end
            model_last_data = exp_data;
            prev_data = exp_data;
            tick();
            if (k == 3) begin
                fetch_req = 1'b0;
                data_req  = 1'b0;
            end
        end
        n_tests++;
        if ({fetch_gnt, data_gnt} !== 2'b00) begin
            n_fail++;
            $display("FAIL tie_drain: fetch_gnt=%b data_gnt=%b, required 0", fetch_gnt, data_gnt);
        end
        tick();
    endtask

    task automatic test_random();
        bit          is_data, rw;
        logic [31:0] a;
        int          r;
        for (int n = 0; n < 40; n++) begin
            is_data = 1'($urandom_range(0, 1));
            rw      = is_data ? 1'($urandom_range(0, 1)) : 1'b0;
            r       = $urandom_range(0, 9);
            if (r < 7) a = 32'($urandom_range(0, 63));
            else if (r == 7) a = 32'd8191;
            else if (r == 8) a = 32'd8192 + 32'($urandom_range(0, 100));
            else a = $urandom | 32'h8000_0000;
            do_access(is_data, rw, a, $urandom);
            repeat ($urandom_range(0, 2)) tick();
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        fetch_req = 1'b0; fetch_a = '0;
        data_req = 1'b0; data_rw = 1'b0; data_a = '0; data_din = '0;
        pl_en = 1'b0; pl_a = '0; pl_d = '0;
        model_reset();
        test_reset();
        preload();
        test_single_fetch();
        test_write_read();
        test_out_of_range();
        test_reset_mid_access();
        test_tie();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/memory_arbiter.md
# memory_arbiter

Shares the single-port synchronous `random_access_memory` between two requesters: instruction fetch and data (load/store). It sits between `control_unit` and the RAM instance. It serialises accesses through a 3-state sequencer, returns read data with a valid pulse, and suppresses out-of-range accesses.

## Interface
- `MEM_WORDS`, default 8192: number of 32-bit words in the RAM; word addresses `>= MEM_WORDS` are out of range.
- `clk` input, 1 bit: the single clock; all state changes on its rising edge.
- `rst_n` input, 1 bit: reset, asynchronous, active-low.
- `fetch_req` input, 1 bit: fetch read request, level.
- `fetch_a` input, 32 bits: fetch word address.
- `fetch_gnt` output, 1 bit: one-cycle pulse; fetch request accepted.
- `fetch_valid` output, 1 bit: one-cycle pulse; `fetch_dout` is valid.
- `fetch_dout` output, 32 bits: fetch read data, held until the next fetch response.
- `data_req` input, 1 bit: data request, level.
- `data_rw` input, 1 bit: 1 = write, 0 = read.
- `data_a` input, 32 bits: data word address.
- `data_din` input, 32 bits: write data.
- `data_gnt` output, 1 bit: one-cycle pulse; data request accepted.
- `data_valid` output, 1 bit: one-cycle pulse; read data valid, or write acknowledged.
- `data_dout` output, 32 bits: data read data, held until the next data read response.
- `ram_a` output, 32 bits: RAM address.
- `ram_din` output, 32 bits: RAM write data.
- `ram_rw` output, 1 bit: RAM write enable.
- `ram_dout` input, 32 bits: RAM read data, registered inside the RAM.

## Operation
- States: IDLE, ISSUE, WAIT. Reset state is IDLE.
- Arbitration happens at an edge where the state is IDLE or WAIT and at least one request is high.
  - The winner's address, data and rw are registered onto `ram_a`, `ram_din` and `ram_rw`.
  - The winner's `*_gnt` is set for one cycle.
  - The state goes to ISSUE.
  - The arbiter records the winner identity and whether the access is a read or a write.
- ISSUE -> WAIT unconditionally. During ISSUE the RAM samples `ram_*` at the closing edge.
- At the edge leaving WAIT:
  - `ram_dout` is captured into the winner's `*_dout` (reads only).
  - The winner's `*_valid` is set for one cycle.
  - At the same edge the next arbitration happens (WAIT -> ISSUE) if any request is high; otherwise the state goes to IDLE.
- `ram_rw` is 1 only during an ISSUE cycle of an in-range data write; it is 0 in all other cycles. `ram_a` and `ram_din` hold their last values outside ISSUE.
- Fetch is always a read; `fetch_rw` does not exist.
- Out-of-range address (`a >= MEM_WORDS`):
  - The access is still granted and sequenced.
  - `ram_rw` is forced to 0, so the write is dropped.
  - A read returns 0 in `*_dout`; `valid` still pulses.
- Requester rules:
  - Hold `req`, address, `rw` and `din` stable until `gnt`.
  - May drop `req` before `gnt`; no grant then results.
  - Must deassert `req` in the cycle `gnt` is seen, unless it issues a new request.
  - A `req` still high after the `gnt` cycle is treated as a new request.
- Reset (any time, including mid-access):
  - All outputs go to 0, the state to IDLE, and `last_grant` to data.
  - An in-flight access is abandoned: no `valid` is produced.
  - A RAM write already sampled by the RAM stays committed.

## Timing
- Request high before edge E0 with the state IDLE:
  - `gnt` is high in cycle E0..E1.
  - The RAM access occurs at E1.
  - `valid` and `dout` are presented in cycle E2..E3.
- Latency is 2 cycles from grant to valid. Back-to-back throughput is 1 access per 2 cycles, because the next `gnt` coincides with the previous `valid`.
- `*_gnt`, `*_valid` and `ram_*` are all registered; there are no combinational paths from `*_req` to outputs.

## Configuration
- `MEMORY_ARBITER_ROUND_ROBIN_EN`
  - Defined: when both requests are high, the requester not in `last_grant` wins. `last_grant` updates on every grant. Because its reset value is data, the first tie goes to fetch.
  - Undefined: fixed priority; data always beats fetch, and `last_grant` is unused.

## Test plan
- Single fetch: RAM word 5 = 0xE3A00001, fetch_req with fetch_a=5 -> `fetch_gnt` 1 cycle after the request; `fetch_valid` 2 cycles after `gnt` with `fetch_dout`=0xE3A00001; `data_*` outputs stay 0.
- Write then read: data write a=10, din=0xDEADBEEF, then data read a=10 -> `ram_rw`=1 only in the write's ISSUE cycle; the read returns 0xDEADBEEF; `data_valid` pulses twice.
- Tie: both requests held high for 4 accesses -> undefined macro: `data_gnt` 4 times and fetch starved; defined macro: grants alternate fetch, data, fetch, data.
- Out of range: data write a=8192, din=0x1, then read a=8192 -> `ram_rw` never 1; the read returns 0 with `data_valid`=1.
- Reset mid-access: `rst_n` low during WAIT of a fetch read -> no `fetch_valid`; all outputs 0; after release, a new fetch completes normally.
